// File: rtl/iir_rtl_pkg.sv
// Shared widths, coefficients, FSM states and the round/saturate helper for the biquad core.
package iir_rtl_pkg;

   localparam int unsigned DATA_W   = 20;
   localparam int unsigned FRAC_W   = 16;
   localparam int unsigned COEF_W   = 18;
   localparam int unsigned ACC_W    = 44;
   localparam int unsigned PROD_W   = DATA_W + COEF_W;
   localparam int unsigned TAP_W    = 3;
   localparam int unsigned LAST_TAP = 4;

   // Q2.16 coefficients: B0 = 0.25, B1 = 0.5, B2 = 0.25, A1 = -0.5, A2 = 0.25
   localparam logic signed [COEF_W-1:0] B0 = 18'sh04000;
   localparam logic signed [COEF_W-1:0] B1 = 18'sh08000;
   localparam logic signed [COEF_W-1:0] B2 = 18'sh04000;
   localparam logic signed [COEF_W-1:0] A1 = 18'sh38000;
   localparam logic signed [COEF_W-1:0] A2 = 18'sh04000;

   // Feedback taps are subtracted, so the multiplier sees the negated coefficients.
   localparam logic signed [COEF_W-1:0] NEG_A1 = -A1;
   localparam logic signed [COEF_W-1:0] NEG_A2 = -A2;

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_W - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN    = ~Y_MAX;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   // Round half up from Q.32 to Q.16, then clamp to the signed DATA_W range.
   function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] q;
      q = (acc + RND_HALF) >>> FRAC_W;
      if (q > Y_MAX)
         sat_round = DATA_W'(Y_MAX);
      else if (q < Y_MIN)
         sat_round = DATA_W'(Y_MIN);
      else
         sat_round = DATA_W'(q);
   endfunction

endpackage

// File: rtl/iir_mac.sv
// Single signed multiplier with accumulator, shared across the five biquad taps.
module iir_mac
   import iir_rtl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [COEF_W-1:0] b,
   output logic [ACC_W-1:0]  acc
);

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  acc_q;

   // Product plus running sum; acc includes the current product so the core can
   // register the rounded result on the same edge that retires the last tap.
   always_comb begin
      prod = PROD_W'($signed(a)) * PROD_W'($signed(b));
      sum  = acc_q + (en ? ACC_W'(prod) : '0);
      acc  = sum;
   end

   // Accumulator register: cleared when a sample is accepted, advanced per tap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_q <= '0;
      else if (clear)
         acc_q <= '0;
      else if (en)
         acc_q <= sum;
   end

endmodule

// File: rtl/iir_rtl_core.sv
// Biquad IIR core behind an ap_start/ap_done/ap_idle/ap_ready block handshake.
module iir_rtl_core
   import iir_rtl_pkg::*;
(
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              ap_start,
   input  logic [DATA_W-1:0] x,
   output logic              ap_done,
   output logic              ap_ready,
   output logic              ap_idle,
   output logic [DATA_W-1:0] ap_return
);

   state_t             state_q, state_d;
   logic [TAP_W-1:0]   tap_q, tap_d;
   logic               load_c;
   logic               mac_en_c;
   logic [DATA_W-1:0]  mac_a_c;
   logic [COEF_W-1:0]  mac_b_c;
   logic [ACC_W-1:0]   acc_c;
   logic [DATA_W-1:0]  x0, x1, x2, y1, y2;

   // Next-state logic: accept a start in IDLE or DONE, walk taps 0..4 in MAC.
   always_comb begin
      state_d  = state_q;
      tap_d    = tap_q;
      load_c   = 1'b0;
      mac_en_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (ap_start) begin
               load_c  = 1'b1;
               tap_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            mac_en_c = 1'b1;
            if (tap_q == TAP_W'(LAST_TAP))
               state_d = DONE;
            else
               tap_d = tap_q + TAP_W'(1);
         end
         DONE: begin
            if (ap_start) begin
               load_c  = 1'b1;
               tap_d   = '0;
               state_d = MAC;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Tap mux: select the history sample and coefficient for the current tap.
   always_comb begin
      mac_a_c = x0;
      mac_b_c = B0;
      case (tap_q)
         TAP_W'(0): begin mac_a_c = x0; mac_b_c = B0;     end
         TAP_W'(1): begin mac_a_c = x1; mac_b_c = B1;     end
         TAP_W'(2): begin mac_a_c = x2; mac_b_c = B2;     end
         TAP_W'(3): begin mac_a_c = y1; mac_b_c = NEG_A1; end
         TAP_W'(4): begin mac_a_c = y2; mac_b_c = NEG_A2; end
         default:   begin mac_a_c = x0; mac_b_c = B0;     end
      endcase
   end

   iir_mac u_mac (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .clear (load_c),
      .en    (mac_en_c),
      .a     (mac_a_c),
      .b     (mac_b_c),
      .acc   (acc_c)
   );

   // FSM state and tap counter registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         tap_q   <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
      end
   end

   // Sample capture, result register and history shift on leaving DONE.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         x0        <= '0;
         x1        <= '0;
         x2        <= '0;
         y1        <= '0;
         y2        <= '0;
         ap_return <= '0;
      end else begin
         if (state_q == MAC && tap_q == TAP_W'(LAST_TAP))
            ap_return <= sat_round($signed(acc_c));
         if (state_q == DONE) begin
            x2 <= x1;
            x1 <= x0;
            y2 <= y1;
            y1 <= ap_return;
         end
         if (load_c)
            x0 <= x;
      end
   end

   // Registered handshake outputs derived from the upcoming state.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ap_done  <= 1'b0;
         ap_ready <= 1'b0;
         ap_idle  <= 1'b1;
      end else begin
         ap_done  <= (state_d == DONE);
         ap_ready <= (state_d == DONE);
         ap_idle  <= (state_d == IDLE);
      end
   end

endmodule

// File: tb/tb_iir_rtl_core.sv
// Randomized bench for iir_rtl_core against a plain-arithmetic difference-equation model.
module tb_iir_rtl_core;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        ap_start;
   logic [19:0] x;
   logic        ap_done;
   logic        ap_ready;
   logic        ap_idle;
   logic [19:0] ap_return;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference coefficients as integers scaled by 2^16.
   localparam longint CB0 = 16384;
   localparam longint CB1 = 32768;
   localparam longint CB2 = 16384;
   localparam longint CA1 = -32768;
   localparam longint CA2 = 16384;

   longint xh1, xh2, yh1, yh2;
   logic [19:0] imp_exp [3] = '{20'h04000, 20'h0A000, 20'h08000};

   iir_rtl_core dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .ap_start  (ap_start),
      .x         (x),
      .ap_done   (ap_done),
      .ap_ready  (ap_ready),
      .ap_idle   (ap_idle),
      .ap_return (ap_return)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      xh1 = 0; xh2 = 0; yh1 = 0; yh2 = 0;
   endtask

   // y[n] = B0 x + B1 x1 + B2 x2 - A1 y1 - A2 y2, round half up, clamp.
   task automatic model_step(input logic [19:0] xin, output logic [19:0] yout);
      longint xs, acc, y;
      xs  = longint'($signed(xin));
      acc = CB0 * xs + CB1 * xh1 + CB2 * xh2 - CA1 * yh1 - CA2 * yh2;
      y   = (acc + 32768) >>> 16;
      if (y > 524287)  y = 524287;
      if (y < -524288) y = -524288;
      xh2 = xh1; xh1 = xs;
      yh2 = yh1; yh1 = y;
      yout = 20'(y);
   endtask

   function automatic logic [19:0] gen_x(input int mode, input int i);
      logic [31:0] r;
      r = $urandom;
      case (mode)
         1:       return 20'h7FFFF;
         2:       return 20'h80000;
         3:       return (i == 0) ? 20'h10000 : 20'h00000;
         default: return r[31] ? {{3{r[16]}}, r[16:0]} : r[19:0];
      endcase
   endfunction

   // Run n samples; hold keeps ap_start high so DONE chains straight into MAC.
   task automatic run_stream(input int n, input int mode, input bit hold);
      for (int i = 0; i < n; i++) begin
         logic [19:0] xv, yexp;
         int extra, c;
         bit seen;
         xv = gen_x(mode, i);
         model_step(xv, yexp);
         extra = $urandom_range(0, 2);
         x = xv;
         ap_start = 1'b1;
         @(posedge ap_clk); #1;
         x = 20'($urandom);
         c = 1;
         seen = 1'b0;
         while (c < 20 && !seen) begin
            ap_start = hold ? (i < n - 1) : (c <= extra);
            chk("idle_busy", 32'(ap_idle), 32'd0);
            @(posedge ap_clk); #1;
            c++;
            if (ap_done) seen = 1'b1;
         end
         chk("done_seen", 32'(seen), 32'd1);
         chk("latency", c, 32'd6);
         chk("ready", 32'(ap_ready), 32'd1);
         chk("idle_done", 32'(ap_idle), 32'd0);
         chk("ret", 32'(ap_return), 32'(yexp));
         if (mode == 3 && i < 3)
            chk("impulse", 32'(ap_return), 32'(imp_exp[i]));
         if (!hold) begin
            @(posedge ap_clk); #1;
            chk("done_pulse", 32'(ap_done), 32'd0);
            chk("idle_back", 32'(ap_idle), 32'd1);
         end
      end
      if (hold) begin
         @(posedge ap_clk); #1;
         chk("done_pulse", 32'(ap_done), 32'd0);
         chk("idle_back", 32'(ap_idle), 32'd1);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      ap_rst_n = 1'b0;
      ap_start = 1'b0;
      x        = '0;
      model_reset();
      repeat (3) @(posedge ap_clk);
      #1;
      chk("rst_idle", 32'(ap_idle), 32'd1);
      chk("rst_done", 32'(ap_done), 32'd0);
      chk("rst_ready", 32'(ap_ready), 32'd0);
      chk("rst_ret", 32'(ap_return), 32'd0);
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;

      // Impulse followed by zeros; response must decay toward zero.
      run_stream(21, 3, 1'b0);
      r = int'($signed(ap_return));
      chk("decay", 32'(r >= -4 && r <= 4), 32'd1);

      // Isolated starts with ap_start lingering into early MAC cycles.
      run_stream(5, 0, 1'b0);

      // Back-to-back with ap_start held.
      run_stream(10, 0, 1'b1);

      // Saturation at both rails.
      run_stream(20, 1, 1'b1);
      chk("sat_hi", 32'(ap_return), 32'h7FFFF);
      run_stream(20, 2, 1'b1);
      chk("sat_lo", 32'(ap_return), 32'h80000);

      // Reset in the middle of a run discards the sample and all history.
      x = 20'h12345;
      ap_start = 1'b1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b0;
      #1;
      chk("mid_rst_idle", 32'(ap_idle), 32'd1);
      chk("mid_rst_done", 32'(ap_done), 32'd0);
      chk("mid_rst_ret", 32'(ap_return), 32'd0);
      @(posedge ap_clk); #1;
      chk("mid_rst_idle2", 32'(ap_idle), 32'd1);
      chk("mid_rst_ready2", 32'(ap_ready), 32'd0);
      ap_rst_n = 1'b1;
      model_reset();
      @(posedge ap_clk); #1;
      run_stream(3, 3, 1'b0);

      // Long random run mixing isolated and chained samples.
      for (int b = 0; b < 20; b++)
         run_stream(50, 0, b[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iir_rtl_core.md
# iir_rtl_core

Hand-written RTL second-order IIR (biquad) core that responds to the same block-level start/done/idle/ready handshake as our HLS filter core, so it drops into the bench top in place of the HLS instance. Each accepted start consumes one signed 20-bit sample and returns one filtered, rounded and saturated 20-bit output. A single time-shared multiplier evaluates the five taps sequentially; the integrated logic analyzer probes the handshake and data unchanged.

## Interface
- DATA_W, 20: sample and result width, signed two's complement.
- FRAC_W, 16: fractional bits of samples and results, Q4.16, so 20'h1_0000 = 1.0.
- COEF_W, 18: coefficient width, signed Q2.16.
- ACC_W, 44: accumulator width, Q.32 internally.

Ports:
- ap_clk  in  1  sole clock.
- ap_rst_n  in  1  reset; asynchronous assert, active-low. Deassertion is synchronised externally.
- ap_start  in  1  request; sampled only in IDLE or DONE.
- x  in  DATA_W  input sample; captured in the cycle ap_start is accepted.
- ap_done  out  1  one-cycle pulse; ap_return valid.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- ap_idle  out  1  high only in IDLE.
- ap_return  out  DATA_W  filtered output; registered, holds until the next ap_done.

## Operation
- Difference equation: y[n] = B0·x[n] + B1·x[n-1] + B2·x[n-2] − A1·y[n-1] − A2·y[n-2].
- History registers x1, x2, y1, y2 reset to 0.
- Default coefficients: B0 = 0.25, B1 = 0.5, B2 = 0.25, A1 = −0.5, A2 = 0.25.
- FSM states:
  - IDLE: ap_idle = 1. If ap_start = 1, latch x into x0, clear the accumulator, go to MAC with tap = 0.
  - MAC: add one product per cycle, taps 0..4 in order B0·x0, B1·x1, B2·x2, −A1·y1, −A2·y2. After tap 4, go to DONE.
  - DONE: ap_done = ap_ready = 1. ap_return and y_new are registered at entry. At the end of the cycle, shift history: x2←x1, x1←x0, y2←y1, y1←y_new.
    - If ap_start = 1, latch the new x, clear the accumulator and go to MAC; ap_idle stays 0.
    - Otherwise go to IDLE.
- Arithmetic:
  - Product is DATA_W+COEF_W bits, sign-extended to ACC_W.
  - y_new = sat_DATA_W((acc + 2^(FRAC_W−1)) >>> FRAC_W): round half up, then clamp to [20'h80000, 20'h7FFFF].
  - The saturated value is what enters y1.
- ap_start falling during MAC is ignored; the run completes.
- Reset mid-run: all state clears immediately and the in-flight sample is discarded.

## Timing
- Reset values: ap_idle = 1, ap_done = 0, ap_ready = 0, ap_return = 0, state IDLE, accumulator and history 0.
- Cycle 0: ap_start sampled high in IDLE.
- Cycles 1–5: MAC.
- Cycle 6: ap_done/ap_ready high with the new ap_return.
- Latency is 6 cycles. With ap_start held high, throughput is one result per 6 cycles (DONE → MAC directly).
- ap_idle drops in cycle 1 and rises again only in the cycle after a DONE with ap_start low.
- ap_done is never high for two consecutive cycles.

## Structure
- Package iir_rtl_pkg:
  - B0, B1, B2, A1, A2 as COEF_W localparams.
  - State enum {IDLE, MAC, DONE}.
  - sat_round function.
- Sub-module iir_mac: one signed multiplier plus accumulator, with ports clear, en, a, b, acc. The core holds the FSM, tap mux and history.

## Test plan
- Reset: hold ap_rst_n = 0 → ap_idle = 1, ap_done = 0, ap_ready = 0, ap_return = 0. Assert reset mid-MAC → same values next cycle, and the subsequent impulse behaves as from power-up.
- Impulse: one start with x = 20'h10000, then starts with x = 0 → ap_return sequence 20'h04000, 20'h0A000, 20'h08000, and it decays toward 0.
- Handshake latency: single start pulse → ap_done/ap_ready exactly 6 cycles later for one cycle; ap_idle low for cycles 1–6. Deasserting ap_start in cycle 2 leaves the result unaffected.
- Back-to-back: ap_start held high for 10 samples → ap_done every 6 cycles and ap_idle never high. Results match a bit-accurate model.
- Saturation: x = 20'h7FFFF held for 20 samples → ap_return reaches and stays at 20'h7FFFF. x = 20'h80000 held → reaches and stays at 20'h80000, with no wrap.
- Rounding: random x for 1000 samples versus a reference model using round-half-up and saturate → zero mismatches.
